l2_set_controller: RTL and testbench
====================================

Name: l2_set_controller

Overview:
- Lookup and replacement controller that sits directly upstream of the four L2 data way instances.
- Holds per-set tag/valid/dirty metadata and per-set LRU ages for a 4-way set-associative L2.
- Resolves hit/miss for each request, picks a victim on miss, and sequences eviction and fill.
- Drives the one-hot write enable and index into the data ways.

Parameters:
- INDEX_BITS, 14, set index width; number of sets = 2^INDEX_BITS.
- TAG_BITS, 14, stored tag width.
- WAYS, 4, fixed at 4, not overridable; way number is 2 bits.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller accepts a request; high only in IDLE.
- req_write  input  1  1 = write request, 0 = read request.
- req_index  input  INDEX_BITS  set index.
- req_tag  input  TAG_BITS  request tag.
- resp_valid  output  1  response present.
- resp_ready  input  1  downstream accepts the response.
- resp_hit  output  1  1 = request hit.
- resp_way  output  2  way that now holds the line.
- evict_valid  output  1  dirty victim writeback request.
- evict_ready  input  1  writeback accepted.
- evict_tag  output  TAG_BITS  victim tag.
- evict_index  output  INDEX_BITS  victim set index.
- fill_valid  input  1  one-cycle pulse: line data from memory present on the way data bus.
- way_write  output  4  one-hot write enable to the data ways.
- way_index  output  INDEX_BITS  set index driven to the data ways; equals the captured index.

Behaviour:
- State machine states: IDLE, LOOKUP, EVICT, FILL, RESP.
- Reset (asynchronous, any state, including mid-operation):
  - state returns to IDLE.
  - resp_valid=0, evict_valid=0, way_write=0, resp_hit=0, resp_way=0.
  - evict_tag, evict_index and way_index = 0.
  - req_ready=1 once in IDLE.
  - All valid and dirty bits cleared; every set's ages[w]=w.
  - Any in-flight request is dropped with no response.
- IDLE:
  - req_ready=1.
  - On req_valid: capture write, index and tag; go to LOOKUP.
- LOOKUP (exactly 1 cycle). Hit when a way has valid=1 and a matching tag; at most one way may match.
  - Hit: LRU update on the hit way. If write, set dirty and pulse way_write (one-hot, this cycle only). Go to RESP with resp_hit=1.
  - Miss: victim is the lowest-numbered invalid way; if all ways are valid, the way with age 3.
    - Victim valid and dirty: go to EVICT.
    - Otherwise: go to FILL.
- EVICT:
  - evict_valid=1, with evict_tag and evict_index taken from the victim; held stable until evict_ready.
  - On evict_ready: go to FILL, with evict_valid low in the next cycle.
- FILL:
  - Wait for fill_valid. A fill_valid arriving in any other state is ignored.
  - On fill_valid, in the same cycle: way_write = one-hot victim; tag <= captured tag; valid <= 1; dirty <= captured write; LRU update on the victim. Go to RESP with resp_hit=0.
- RESP:
  - resp_valid=1; resp_hit and resp_way held stable until resp_ready.
  - On resp_ready: go to IDLE.
  - A new request is accepted no earlier than the following cycle.
- LRU update on way w with old age a:
  - Every way in the set with age < a increments by 1.
  - Way w's age becomes 0.
  - Ages within a set always remain a permutation of 0..3.
- Latency:
  - Hit: accepted at cycle 0, resp_valid at cycle 2.
  - Clean miss: FILL entered at cycle 2; resp_valid one cycle after fill_valid.
  - Dirty miss: EVICT at cycle 2.
- way_write is never multi-hot and is never asserted outside LOOKUP (write hit) or the FILL cycle.

Test Plan:
1. Reset, then read index=5, tag=0x0AA -> miss; FILL; after fill_valid, way_write=4'b0001, resp_hit=0, resp_way=0; evict_valid never asserted.
2. Repeat read index=5, tag=0x0AA -> resp_valid at cycle 2, resp_hit=1, resp_way=0, way_write stays 0; same access as a write -> way_write=4'b0001 in the LOOKUP cycle.
3. Fill tags 0x1, 0x2, 0x3, 0x4 into index=7 (ways 0..3), then read tag 0x5 -> victim way 0 (age 3), clean line so no evict, resp_way=0.
4. Write-hit tag 0x2 at index=7 (way 1 dirty), touch ways 2, 3, 0, then miss tag 0x6 -> evict_valid=1, evict_tag=0x2, evict_index=7; holding evict_ready=0 for 5 cycles keeps outputs stable; release -> FILL, resp_way=1.
5. Assert reset_n=0 while in EVICT -> evict_valid drops immediately; after release, req_ready=1; rereading index=7, tag=0x3 misses.
6. Hold resp_ready=0 for 4 cycles in RESP -> resp_valid, resp_hit and resp_way stable; req_ready=0 until the cycle after the handshake.

Source files
------------

// File: rtl/l2_set_controller.sv
// Lookup/replacement controller for a 4-way set-associative L2: per-set tag, valid,
// dirty and LRU-age metadata, hit/miss resolution, victim choice, evict and fill sequencing.
module l2_set_controller #(
   parameter int unsigned INDEX_BITS = 14,
   parameter int unsigned TAG_BITS   = 14
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [INDEX_BITS-1:0] req_index,
   input  logic [TAG_BITS-1:0]   req_tag,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic                  resp_hit,
   output logic [1:0]            resp_way,
   output logic                  evict_valid,
   input  logic                  evict_ready,
   output logic [TAG_BITS-1:0]   evict_tag,
   output logic [INDEX_BITS-1:0] evict_index,
   input  logic                  fill_valid,
   output logic [3:0]            way_write,
   output logic [INDEX_BITS-1:0] way_index
);

   localparam int unsigned WAYS = 4;
   localparam int unsigned SETS = 1 << INDEX_BITS;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      EVICT,
      FILL,
      RESP
   } state_t;

   state_t                state;
   logic                  cap_write;
   logic [INDEX_BITS-1:0] cap_index;
   logic [TAG_BITS-1:0]   cap_tag;
   logic [1:0]            victim_q;

   logic [WAYS-1:0]       valid_mem [SETS];
   logic [WAYS-1:0]       dirty_mem [SETS];
   logic [TAG_BITS-1:0]   tag_mem   [SETS][WAYS];
   logic [1:0]            age_mem   [SETS][WAYS];

   logic [WAYS-1:0]       set_valid;
   logic [WAYS-1:0]       set_dirty;
   logic [WAYS-1:0]       match;
   logic [TAG_BITS-1:0]   set_tag [WAYS];
   logic [1:0]            set_age [WAYS];
   logic [1:0]            new_age [WAYS];
   logic                  hit;
   logic [1:0]            hit_way;
   logic [1:0]            victim;
   logic [1:0]            upd_way;
   logic                  lookup_upd;
   logic                  fill_upd;

   assign way_index = cap_index;

   // Set lookup, victim choice and LRU next-age for the captured index.
   // way_write follows the memory data bus cycle, so it is decoded here from state and fill_valid.
   always_comb begin
      set_valid = valid_mem[cap_index];
      set_dirty = dirty_mem[cap_index];
      hit_way   = 2'd0;
      victim    = 2'd0;
      way_write = 4'b0000;
      for (int w = 0; w < WAYS; w++) begin
         set_tag[w] = tag_mem[cap_index][w];
         set_age[w] = age_mem[cap_index][w];
         match[w]   = set_valid[w] && (set_tag[w] == cap_tag);
      end
      hit = |match;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (match[w]) hit_way = 2'(w);
      end
      for (int w = 0; w < WAYS; w++) begin
         if (set_age[w] == 2'd3) victim = 2'(w);
      end
      // An invalid way always wins over the oldest valid one.
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!set_valid[w]) victim = 2'(w);
      end
      lookup_upd = (state == LOOKUP) && hit;
      fill_upd   = (state == FILL) && fill_valid;
      upd_way    = (state == FILL) ? victim_q : hit_way;
      for (int w = 0; w < WAYS; w++) begin
         if (2'(w) == upd_way)
            new_age[w] = 2'd0;
         else if (set_age[w] < set_age[upd_way])
            new_age[w] = set_age[w] + 2'd1;
         else
            new_age[w] = set_age[w];
      end
      if (lookup_upd && cap_write)
         way_write = 4'b0001 << hit_way;
      else if (fill_upd)
         way_write = 4'b0001 << victim_q;
   end

   // Valid, dirty and age metadata; reset restores an empty cache with ages[w] = w.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned s = 0; s < SETS; s++) begin
            valid_mem[INDEX_BITS'(s)] <= '0;
            dirty_mem[INDEX_BITS'(s)] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               age_mem[INDEX_BITS'(s)][w] <= 2'(w);
            end
         end
      end else begin
         if (lookup_upd || fill_upd) begin
            for (int w = 0; w < WAYS; w++) begin
               age_mem[cap_index][w] <= new_age[w];
            end
         end
         if (lookup_upd && cap_write)
            dirty_mem[cap_index][hit_way] <= 1'b1;
         if (fill_upd) begin
            valid_mem[cap_index][victim_q] <= 1'b1;
            dirty_mem[cap_index][victim_q] <= cap_write;
         end
      end
   end

   // Tags are qualified by valid, so they need no reset.
   always_ff @(posedge clk) begin
      if (fill_upd)
         tag_mem[cap_index][victim_q] <= cap_tag;
   end

   // Control FSM with registered handshake and eviction outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         req_ready   <= 1'b1;
         resp_valid  <= 1'b0;
         resp_hit    <= 1'b0;
         resp_way    <= 2'd0;
         evict_valid <= 1'b0;
         evict_tag   <= '0;
         evict_index <= '0;
         cap_write   <= 1'b0;
         cap_index   <= '0;
         cap_tag     <= '0;
         victim_q    <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  cap_write <= req_write;
                  cap_index <= req_index;
                  cap_tag   <= req_tag;
                  req_ready <= 1'b0;
                  state     <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (hit) begin
                  resp_valid <= 1'b1;
                  resp_hit   <= 1'b1;
                  resp_way   <= hit_way;
                  state      <= RESP;
               end else begin
                  victim_q <= victim;
                  if (set_valid[victim] && set_dirty[victim]) begin
                     evict_valid <= 1'b1;
                     evict_tag   <= set_tag[victim];
                     evict_index <= cap_index;
                     state       <= EVICT;
                  end else begin
                     state <= FILL;
                  end
               end
            end
            EVICT: begin
               if (evict_ready) begin
                  evict_valid <= 1'b0;
                  state       <= FILL;
               end
            end
            FILL: begin
               if (fill_valid) begin
                  resp_valid <= 1'b1;
                  resp_hit   <= 1'b0;
                  resp_way   <= victim_q;
                  state      <= RESP;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_l2_set_controller.sv
// Directed bench for l2_set_controller: hit/miss, LRU victim, dirty eviction,
// reset mid-operation and response backpressure.
module tb_l2_set_controller;

   localparam int unsigned IB = 14;
   localparam int unsigned TB = 14;

   logic          clk;
   logic          reset_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [IB-1:0] req_index;
   logic [TB-1:0] req_tag;
   logic          resp_valid;
   logic          resp_ready;
   logic          resp_hit;
   logic [1:0]    resp_way;
   logic          evict_valid;
   logic          evict_ready;
   logic [TB-1:0] evict_tag;
   logic [IB-1:0] evict_index;
   logic          fill_valid;
   logic [3:0]    way_write;
   logic [IB-1:0] way_index;

   int total = 0;
   int bad   = 0;
   int evict_cnt = 0;

   l2_set_controller #(.INDEX_BITS(IB), .TAG_BITS(TB)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_index(req_index), .req_tag(req_tag),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit), .resp_way(resp_way),
      .evict_valid(evict_valid), .evict_ready(evict_ready), .evict_tag(evict_tag),
      .evict_index(evict_index), .fill_valid(fill_valid),
      .way_write(way_write), .way_index(way_index)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (evict_valid) evict_cnt <= evict_cnt + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one cycle once req_ready is seen; returns in the LOOKUP cycle.
   task automatic issue(input logic w, input logic [IB-1:0] idx, input logic [TB-1:0] tg);
      int n = 0;
      while (!req_ready && n < 50) begin
         tick();
         n++;
      end
      check("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_write = w;
      req_index = idx;
      req_tag   = tg;
      tick();
      req_valid = 1'b0;
   endtask

   // Called in a FILL cycle: pulse fill_valid and check the same-cycle write enable.
   task automatic fill_cycle(input logic [3:0] exp_ww);
      fill_valid = 1'b1;
      #4;
      check("fill_way_write", 32'(way_write), 32'(exp_ww));
      tick();
      fill_valid = 1'b0;
      check("fill_resp_valid", 32'(resp_valid), 32'd1);
   endtask

   task automatic finish_resp(input logic exp_hit, input logic [1:0] exp_way);
      check("resp_valid", 32'(resp_valid), 32'd1);
      check("resp_hit", 32'(resp_hit), 32'(exp_hit));
      check("resp_way", 32'(resp_way), 32'(exp_way));
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("resp_done_valid", 32'(resp_valid), 32'd0);
      check("resp_done_ready", 32'(req_ready), 32'd1);
   endtask

   task automatic hit_op(input logic w, input logic [IB-1:0] idx, input logic [TB-1:0] tg,
                         input logic [1:0] way);
      logic [3:0] exp_ww;
      exp_ww = w ? (4'b0001 << way) : 4'b0000;
      issue(w, idx, tg);
      #4;
      check("lookup_way_write", 32'(way_write), 32'(exp_ww));
      check("way_index", 32'(way_index), 32'(idx));
      tick();
      finish_resp(1'b1, way);
   endtask

   task automatic clean_miss(input logic w, input logic [IB-1:0] idx, input logic [TB-1:0] tg,
                             input logic [1:0] way);
      issue(w, idx, tg);
      tick();
      check("miss_no_evict", 32'(evict_valid), 32'd0);
      fill_cycle(4'b0001 << way);
      finish_resp(1'b0, way);
   endtask

   initial begin
      int ev0;
      reset_n     = 1'b0;
      req_valid   = 1'b0;
      req_write   = 1'b0;
      req_index   = '0;
      req_tag     = '0;
      resp_ready  = 1'b0;
      evict_ready = 1'b0;
      fill_valid  = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();

      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_evict_valid", 32'(evict_valid), 32'd0);
      check("rst_way_write", 32'(way_write), 32'd0);
      check("rst_resp_hit", 32'(resp_hit), 32'd0);
      check("rst_resp_way", 32'(resp_way), 32'd0);
      check("rst_evict_tag", 32'(evict_tag), 32'd0);
      check("rst_evict_index", 32'(evict_index), 32'd0);
      check("rst_way_index", 32'(way_index), 32'd0);

      // Cold read miss fills way 0 with no writeback
      ev0 = evict_cnt;
      clean_miss(1'b0, 14'd5, 14'h0AA, 2'd0);
      check("t1_no_evict_seen", 32'(evict_cnt - ev0), 32'd0);

      // Read hit, stray fill_valid in IDLE, then write hit
      hit_op(1'b0, 14'd5, 14'h0AA, 2'd0);
      fill_valid = 1'b1;
      #4;
      check("stray_fill_way_write", 32'(way_write), 32'd0);
      tick();
      fill_valid = 1'b0;
      check("stray_fill_resp", 32'(resp_valid), 32'd0);
      hit_op(1'b1, 14'd5, 14'h0AA, 2'd0);

      // Fill index 7; ages become {w0:3,w1:2,w2:1,w3:0}, so tag 5 replaces way 0
      clean_miss(1'b0, 14'd7, 14'h1, 2'd0);
      clean_miss(1'b0, 14'd7, 14'h2, 2'd1);
      clean_miss(1'b0, 14'd7, 14'h3, 2'd2);
      clean_miss(1'b0, 14'd7, 14'h4, 2'd3);
      clean_miss(1'b0, 14'd7, 14'h5, 2'd0);

      // Dirty way 1, touch 2,3,0 so way 1 is oldest, then miss evicts it
      hit_op(1'b1, 14'd7, 14'h2, 2'd1);
      hit_op(1'b0, 14'd7, 14'h3, 2'd2);
      hit_op(1'b0, 14'd7, 14'h4, 2'd3);
      hit_op(1'b0, 14'd7, 14'h5, 2'd0);
      issue(1'b0, 14'd7, 14'h6);
      tick();
      check("evict_valid", 32'(evict_valid), 32'd1);
      check("evict_tag", 32'(evict_tag), 32'h2);
      check("evict_index", 32'(evict_index), 32'd7);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("evict_hold_valid", 32'(evict_valid), 32'd1);
         check("evict_hold_tag", 32'(evict_tag), 32'h2);
         check("evict_hold_index", 32'(evict_index), 32'd7);
         check("evict_hold_ww", 32'(way_write), 32'd0);
      end
      evict_ready = 1'b1;
      tick();
      evict_ready = 1'b0;
      check("evict_released", 32'(evict_valid), 32'd0);
      fill_cycle(4'b0010);
      finish_resp(1'b0, 2'd1);

      // Dirty way 2 (tag 3) and make it oldest, then reset while in EVICT
      hit_op(1'b1, 14'd7, 14'h3, 2'd2);
      hit_op(1'b0, 14'd7, 14'h4, 2'd3);
      hit_op(1'b0, 14'd7, 14'h5, 2'd0);
      hit_op(1'b0, 14'd7, 14'h6, 2'd1);
      issue(1'b0, 14'd7, 14'h7);
      tick();
      check("evict2_valid", 32'(evict_valid), 32'd1);
      check("evict2_tag", 32'(evict_tag), 32'h3);
      reset_n = 1'b0;
      #1;
      check("async_rst_evict", 32'(evict_valid), 32'd0);
      check("async_rst_resp", 32'(resp_valid), 32'd0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      check("post_rst_ready", 32'(req_ready), 32'd1);
      clean_miss(1'b0, 14'd7, 14'h3, 2'd0);

      // Response backpressure on a hit
      issue(1'b0, 14'd7, 14'h3);
      tick();
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("bp_hold_valid", 32'(resp_valid), 32'd1);
         check("bp_hold_hit", 32'(resp_hit), 32'd1);
         check("bp_hold_way", 32'(resp_way), 32'd0);
         check("bp_hold_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      check("bp_hs_ready", 32'(req_ready), 32'd0);
      tick();
      resp_ready = 1'b0;
      check("bp_after_valid", 32'(resp_valid), 32'd0);
      check("bp_after_ready", 32'(req_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
